// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the execute stage and its divider.
package ex_stage_pkg;

  localparam int unsigned ID_TO_EX_WD  = 159;
  localparam int unsigned EX_TO_MEM_WD = 76;
  localparam int unsigned STALL_BUS    = 6;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned DIV_CNT_W    = 5;

  localparam int unsigned STALL_EX  = 2;
  localparam int unsigned STALL_MEM = 3;
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] FUNC_MFHI   = 6'b010000;
  localparam logic [5:0] FUNC_MTHI   = 6'b010001;
  localparam logic [5:0] FUNC_MFLO   = 6'b010010;
  localparam logic [5:0] FUNC_MTLO   = 6'b010011;
  localparam logic [5:0] FUNC_DIV    = 6'b011010;
  localparam logic [5:0] FUNC_DIVU   = 6'b011011;

  // alu_op bit positions
  localparam int unsigned OP_ADD  = 11;
  localparam int unsigned OP_SUB  = 10;
  localparam int unsigned OP_SLT  = 9;
  localparam int unsigned OP_SLTU = 8;
  localparam int unsigned OP_AND  = 7;
  localparam int unsigned OP_NOR  = 6;
  localparam int unsigned OP_OR   = 5;
  localparam int unsigned OP_XOR  = 4;
  localparam int unsigned OP_SLL  = 3;
  localparam int unsigned OP_SRL  = 2;
  localparam int unsigned OP_SRA  = 1;
  localparam int unsigned OP_LUI  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] data1;
    logic [31:0] data2;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } ex_mem_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// 32-iteration restoring divider on operand magnitudes with sign fix-up on the final step.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              ack_i,
  input  logic              signed_op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_o,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o
);

  div_state_e           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0]    quo_q, rem_q, dvs_q;
  logic                 qneg_q, rneg_q;

  logic [DATA_W:0]      shifted, diff;
  logic                 ge;
  logic [DATA_W-1:0]    quo_d, rem_d, a_mag, b_mag;

  assign a_mag = (signed_op_i && a_i[DATA_W-1]) ? (~a_i + 32'd1) : a_i;
  assign b_mag = (signed_op_i && b_i[DATA_W-1]) ? (~b_i + 32'd1) : b_i;

  // One restoring step: bit 32 of the trial difference is set when it went negative
  always_comb begin
    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[DATA_W];
    quo_d   = {quo_q[DATA_W-2:0], ge};
    rem_d   = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: if (start_i) begin
          state_q <= DIV_BUSY;
          cnt_q   <= '0;
          quo_q   <= a_mag;
          rem_q   <= '0;
          dvs_q   <= b_mag;
          // a zero divisor keeps the all-ones quotient unsigned
          qneg_q  <= signed_op_i && (a_i[DATA_W-1] ^ b_i[DATA_W-1]) && (b_i != '0);
          rneg_q  <= signed_op_i && a_i[DATA_W-1];
        end
        DIV_BUSY: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + DIV_CNT_W'(1);
          if (cnt_q == DIV_CNT_W'(31)) state_q <= DIV_DONE;
        end
        DIV_DONE: if (ack_i) state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  assign busy_o      = (state_q == DIV_BUSY);
  assign done_o      = (state_q == DIV_DONE);
  assign wr_o        = busy_o && (cnt_q == DIV_CNT_W'(31));
  assign quotient_o  = qneg_q ? (~quo_d + 32'd1) : quo_d;
  assign remainder_o = rneg_q ? (~rem_d + 32'd1) : rem_d;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, HI/LO with divider, and EX/MEM bus.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [DATA_W-1:0]       data_sram_addr,
  output logic [DATA_W-1:0]       data_sram_wdata,
  output logic                    stallreq_for_div
);

  id_ex_t            ex_q;
  ex_mem_t           mem_bus;
  logic              ex_load;
  logic [DATA_W-1:0] src1, src2, alu_res, result, hi_q, lo_q;
  logic              is_special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_div;
  logic              div_busy, div_done, div_wr;
  logic [DATA_W-1:0] div_quo, div_rem;
  logic              unused_bits;

  assign ex_load = (stall[STALL_EX] == NO_STOP);

  // Pipeline register: bubble when EX stops but MEM moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (!ex_load && (stall[STALL_MEM] == NO_STOP)) begin
      ex_q <= '0;
    end else if (ex_load) begin
      ex_q <= id_ex_t'(id_to_ex_bus);
    end
  end

  assign is_special = (ex_q.inst[31:26] == OPC_SPECIAL);
  assign is_mfhi    = is_special && (ex_q.inst[5:0] == FUNC_MFHI);
  assign is_mflo    = is_special && (ex_q.inst[5:0] == FUNC_MFLO);
  assign is_mthi    = is_special && (ex_q.inst[5:0] == FUNC_MTHI);
  assign is_mtlo    = is_special && (ex_q.inst[5:0] == FUNC_MTLO);
  assign is_div     = is_special && ((ex_q.inst[5:0] == FUNC_DIV) || (ex_q.inst[5:0] == FUNC_DIVU));

  always_comb begin
    src1 = '0;
    src2 = '0;
    if (ex_q.sel_src1[0]) src1 = src1 | ex_q.data1;
    if (ex_q.sel_src1[1]) src1 = src1 | ex_q.pc;
    if (ex_q.sel_src1[2]) src1 = src1 | {27'b0, ex_q.inst[10:6]};
    if (ex_q.sel_src2[0]) src2 = src2 | ex_q.data2;
    if (ex_q.sel_src2[1]) src2 = src2 | {{16{ex_q.inst[15]}}, ex_q.inst[15:0]};
    if (ex_q.sel_src2[2]) src2 = src2 | 32'd8;
    if (ex_q.sel_src2[3]) src2 = src2 | {16'b0, ex_q.inst[15:0]};
  end

  always_comb begin
    alu_res = '0;
    if (ex_q.alu_op[OP_ADD])  alu_res = alu_res | (src1 + src2);
    if (ex_q.alu_op[OP_SUB])  alu_res = alu_res | (src1 - src2);
    if (ex_q.alu_op[OP_SLT])  alu_res = alu_res | {31'b0, ($signed(src1) < $signed(src2))};
    if (ex_q.alu_op[OP_SLTU]) alu_res = alu_res | {31'b0, (src1 < src2)};
    if (ex_q.alu_op[OP_AND])  alu_res = alu_res | (src1 & src2);
    if (ex_q.alu_op[OP_NOR])  alu_res = alu_res | ~(src1 | src2);
    if (ex_q.alu_op[OP_OR])   alu_res = alu_res | (src1 | src2);
    if (ex_q.alu_op[OP_XOR])  alu_res = alu_res | (src1 ^ src2);
    if (ex_q.alu_op[OP_SLL])  alu_res = alu_res | (src2 << src1[4:0]);
    if (ex_q.alu_op[OP_SRL])  alu_res = alu_res | (src2 >> src1[4:0]);
    if (ex_q.alu_op[OP_SRA])  alu_res = alu_res | 32'($signed(src2) >>> src1[4:0]);
    if (ex_q.alu_op[OP_LUI])  alu_res = alu_res | {src2[15:0], 16'b0};
  end

  assign result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

  div_unit u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (is_div),
    .ack_i       (ex_load),
    .signed_op_i (ex_q.inst[5:0] == FUNC_DIV),
    .a_i         (ex_q.data1),
    .b_i         (ex_q.data2),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .wr_o        (div_wr),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  // Stall while the divide is about to start (IDLE) or iterating (BUSY)
  assign stallreq_for_div = is_div && (div_busy || !div_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (div_wr) begin
      hi_q <= div_rem;
      lo_q <= div_quo;
    end else if (ex_load && is_mthi) begin
      hi_q <= ex_q.data1;
    end else if (ex_load && is_mtlo) begin
      lo_q <= ex_q.data1;
    end
  end

  always_comb begin
    mem_bus            = '0;
    mem_bus.pc         = ex_q.pc;
    mem_bus.ram_en     = ex_q.ram_en;
    mem_bus.ram_wen    = ex_q.ram_wen;
    mem_bus.sel_rf_res = ex_q.sel_rf_res;
    mem_bus.rf_we      = ex_q.rf_we;
    mem_bus.rf_waddr   = ex_q.rf_waddr;
    mem_bus.result     = result;
  end

  assign ex_to_mem_bus   = mem_bus;
  assign data_sram_en    = ex_q.ram_en;
  assign data_sram_wen   = ex_q.ram_wen;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = ex_q.data2;

  assign unused_bits = ^{ex_q.inst[25:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against a behavioural model.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0] ex_to_mem_bus;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        stallreq_for_div;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] hi_m = 32'h0;
  logic [31:0] lo_m = 32'h0;

  ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .id_to_ex_bus     (id_to_ex_bus),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .stallreq_for_div (stallreq_for_div)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
      input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2, input logic ren,
      input logic [3:0] wen, input logic we, input logic [4:0] wa, input logic srr,
      input logic [31:0] d1, input logic [31:0] d2);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, srr, d1, d2};
  endfunction

  // Reference ALU straight from the operation table
  function automatic logic [31:0] ref_alu(input logic [158:0] b);
    logic [31:0] pc, inst, d1, d2, a, c, r;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    pc = b[158:127]; inst = b[126:95]; op = b[94:83]; s1 = b[82:80]; s2 = b[79:76];
    d1 = b[63:32];  d2 = b[31:0];
    a = 32'h0; c = 32'h0;
    if (s1 == 3'b001) a = d1;
    else if (s1 == 3'b010) a = pc;
    else if (s1 == 3'b100) a = {27'h0, inst[10:6]};
    if (s2 == 4'b0001) c = d2;
    else if (s2 == 4'b0010) c = {{16{inst[15]}}, inst[15:0]};
    else if (s2 == 4'b0100) c = 32'd8;
    else if (s2 == 4'b1000) c = {16'h0, inst[15:0]};
    case (op)
      12'h800: r = a + c;
      12'h400: r = a - c;
      12'h200: r = ($signed(a) < $signed(c)) ? 32'd1 : 32'd0;
      12'h100: r = (a < c) ? 32'd1 : 32'd0;
      12'h080: r = a & c;
      12'h040: r = ~(a | c);
      12'h020: r = a | c;
      12'h010: r = a ^ c;
      12'h008: r = c << a[4:0];
      12'h004: r = c >> a[4:0];
      12'h002: r = $signed(c) >>> a[4:0];
      12'h001: r = {c[15:0], 16'h0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic [75:0] ref_mem(input logic [158:0] b, input logic [31:0] hi, input logic [31:0] lo);
    logic [31:0] inst, res;
    inst = b[126:95];
    res = ref_alu(b);
    if (inst[31:26] == 6'h00 && inst[5:0] == 6'h10) res = hi;
    if (inst[31:26] == 6'h00 && inst[5:0] == 6'h12) res = lo;
    return {b[158:127], b[75], b[74:71], b[64], b[70], b[69:65], res};
  endfunction

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = sa / sb; r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    ua = {32'h0, a}; ub = {32'h0, b};
    uq = ua / ub; ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  function automatic logic [158:0] rand_alu();
    logic [31:0] inst;
    int k;
    logic [11:0] op;
    inst = $urandom();
    inst[31:26] = 6'($urandom_range(1, 63));
    k = $urandom_range(0, 12);
    op = (k == 12) ? 12'h0 : (12'h1 << k);
    return mk($urandom(), inst, op, 3'(3'b1 << $urandom_range(0, 2)),
              4'(4'b1 << $urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom()),
              1'($urandom_range(0, 1)), 5'($urandom()), 1'($urandom_range(0, 1)),
              $urandom(), $urandom());
  endfunction

  function automatic logic [158:0] special(input logic [5:0] func, input logic [31:0] d1, input logic [31:0] d2);
    logic [31:0] inst;
    inst = $urandom();
    inst[31:26] = 6'h00;
    inst[5:0] = func;
    return mk($urandom(), inst, 12'h0, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'($urandom()), 1'b0, d1, d2);
  endfunction

  task automatic check_out(input logic [158:0] b);
    chk("bus", ex_to_mem_bus, ref_mem(b, hi_m, lo_m));
    chk("sram_en", 76'(data_sram_en), 76'(b[75]));
    chk("sram_wen", 76'(data_sram_wen), 76'(b[74:71]));
    chk("sram_addr", 76'(data_sram_addr), 76'(ref_alu(b)));
    chk("sram_wdata", 76'(data_sram_wdata), 76'(b[31:0]));
  endtask

  // Load one instruction with no stall and check it in EX; MTHI/MTLO land at the next load
  task automatic run_instr(input logic [158:0] b);
    logic [31:0] inst;
    id_to_ex_bus = b;
    stall = 6'b0;
    @(posedge clk); #1;
    check_out(b);
    inst = b[126:95];
    if (inst[31:26] == 6'h00 && inst[5:0] == 6'h11) hi_m = b[63:32];
    if (inst[31:26] == 6'h00 && inst[5:0] == 6'h13) lo_m = b[63:32];
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int cnt;
    logic [63:0] e;
    id_to_ex_bus = special(sgn ? 6'h1A : 6'h1B, a, b);
    stall = 6'b0;
    @(posedge clk); #1;
    stall = 6'b001111;
    id_to_ex_bus = rand_alu();
    cnt = 0;
    while (stallreq_for_div && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk("div_stall_cycles", 76'(cnt), 76'd33);
    e = ref_div(sgn, a, b);
    hi_m = e[63:32];
    lo_m = e[31:0];
  endtask

  initial begin
    logic [158:0] b;
    logic [31:0] x, y;
    rst = 1'b1;
    stall = 6'b0;
    id_to_ex_bus = rand_alu();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", ex_to_mem_bus, 76'h0);
    chk("rst_en", 76'(data_sram_en), 76'h0);
    chk("rst_addr", 76'(data_sram_addr), 76'h0);
    chk("rst_stallreq", 76'(stallreq_for_div), 76'h0);
    rst = 1'b0;

    // ORI-form
    run_instr(mk(32'h0040_0000, {6'h0D, 5'd1, 5'd2, 16'hFFFF}, 12'h020, 3'b001, 4'b1000,
                 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0000_1234, 32'h0));
    chk("ori_res", 76'(ex_to_mem_bus[31:0]), 76'h0000_FFFF);
    chk("ori_fwd", 76'(ex_to_mem_bus[37:32]), 76'h22);
    // JAL-form
    run_instr(mk(32'hBFC0_0000, {6'h03, 26'h0}, 12'h800, 3'b010, 4'b0100,
                 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0));
    chk("jal_res", 76'(ex_to_mem_bus[31:0]), 76'hBFC0_0008);
    // SW-form
    run_instr(mk(32'hBFC0_0010, {6'h2B, 5'd1, 5'd2, 16'hFFFC}, 12'h800, 3'b001, 4'b0010,
                 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF));
    chk("sw_en", 76'(data_sram_en), 76'h1);
    chk("sw_addr", 76'(data_sram_addr), 76'h0FFC);
    chk("sw_wen", 76'(data_sram_wen), 76'hF);
    chk("sw_wdata", 76'(data_sram_wdata), 76'hDEAD_BEEF);

    for (int i = 0; i < 200; i++) run_instr(rand_alu());

    // HI/LO moves interleaved with ALU traffic
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: run_instr(special(6'h11, $urandom(), $urandom()));
        1: run_instr(special(6'h13, $urandom(), $urandom()));
        2: run_instr(special(6'h10, $urandom(), $urandom()));
        3: run_instr(special(6'h12, $urandom(), $urandom()));
        default: run_instr(rand_alu());
      endcase
    end
    run_instr(rand_alu());

    // DIV -7/2 then MFLO/MFHI back-to-back
    run_div(1'b1, 32'hFFFF_FFF9, 32'h2);
    run_instr(special(6'h12, $urandom(), $urandom()));
    chk("div_lo", 76'(ex_to_mem_bus[31:0]), 76'hFFFF_FFFD);
    run_instr(special(6'h10, $urandom(), $urandom()));
    chk("div_hi", 76'(ex_to_mem_bus[31:0]), 76'hFFFF_FFFF);

    // DIVU 7/0 with downstream stall held in DONE
    run_div(1'b0, 32'h7, 32'h0);
    stall = 6'b001100;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("done_hold_stallreq", 76'(stallreq_for_div), 76'h0);
    end
    run_instr(special(6'h12, $urandom(), $urandom()));
    chk("divu0_lo", 76'(ex_to_mem_bus[31:0]), 76'hFFFF_FFFF);
    run_instr(special(6'h10, $urandom(), $urandom()));
    chk("divu0_hi", 76'(ex_to_mem_bus[31:0]), 76'h7);

    // Random divides checked through MFLO/MFHI
    for (int i = 0; i < 12; i++) begin
      x = $urandom();
      case ($urandom_range(0, 3))
        0: y = 32'h0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        default: y = $urandom();
      endcase
      run_div(1'($urandom_range(0, 1)), x, y);
      run_instr(special(6'h12, $urandom(), $urandom()));
      run_instr(special(6'h10, $urandom(), $urandom()));
    end

    // rst in the middle of a divide
    run_instr(special(6'h11, $urandom() | 32'h1, 32'h0));
    run_instr(special(6'h13, $urandom() | 32'h1, 32'h0));
    run_instr(rand_alu());
    id_to_ex_bus = special(6'h1A, $urandom(), 32'h3);
    stall = 6'b0;
    @(posedge clk); #1;
    stall = 6'b001111;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    stall = 6'b0;
    id_to_ex_bus = rand_alu();
    @(posedge clk); #1;
    rst = 1'b0;
    hi_m = 32'h0;
    lo_m = 32'h0;
    chk("abort_bus", ex_to_mem_bus, 76'h0);
    chk("abort_stallreq", 76'(stallreq_for_div), 76'h0);
    chk("abort_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}), 76'h0);
    run_instr(special(6'h10, $urandom(), $urandom()));
    chk("abort_hi", 76'(ex_to_mem_bus[31:0]), 76'h0);
    run_instr(special(6'h12, $urandom(), $urandom()));
    chk("abort_lo", 76'(ex_to_mem_bus[31:0]), 76'h0);

    // Bubble and hold
    for (int i = 0; i < 5; i++) begin
      run_instr(rand_alu());
      id_to_ex_bus = rand_alu();
      stall = 6'b000100;
      @(posedge clk); #1;
      chk("bubble_bus", ex_to_mem_bus, 76'h0);
      chk("bubble_en", 76'({data_sram_en, data_sram_wen}), 76'h0);
      b = rand_alu();
      run_instr(b);
      id_to_ex_bus = rand_alu();
      stall = 6'b001100;
      @(posedge clk); #1;
      chk("hold_bus", ex_to_mem_bus, ref_mem(b, hi_m, lo_m));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
